// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants, phase encoding and coordinate width
package vga_timing_pkg;
  localparam int COORD_W = 10;
  localparam int DEF_H_VIDEO = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_VIDEO = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  localparam int H_TOTAL = DEF_H_VIDEO + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VIDEO + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;
  typedef enum logic {IDLE, RUN} run_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis -- position counter, segment phase FSM and end-of-axis wrap
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIDEO_LEN = DEF_H_VIDEO,
  parameter int FRONT_LEN = DEF_H_FRONT,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BACK_LEN = DEF_H_BACK
) (
  input  logic               clk_0,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output phase_t             phase,
  output logic               wrap
);
  localparam logic [COORD_W-1:0] LAST_A = COORD_W'(VIDEO_LEN - 1);
  localparam logic [COORD_W-1:0] LAST_F = COORD_W'(VIDEO_LEN + FRONT_LEN - 1);
  localparam logic [COORD_W-1:0] LAST_S = COORD_W'(VIDEO_LEN + FRONT_LEN + SYNC_LEN - 1);
  localparam logic [COORD_W-1:0] LAST_B = COORD_W'(VIDEO_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);
  phase_t phase_nx;
  logic last;
  // position counter, wraps to zero after the last back-porch count
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) count <= '0;
    else if (en) count <= last ? '0 : count + 1'b1;
  // phase state register
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) phase <= ACTIVE;
    else phase <= phase_nx;
  // next phase: step to the following segment when leaving a segment's final count
  always_comb
    phase_nx = !en ? phase :
               (phase == ACTIVE && count == LAST_A) ? FRONT :
               (phase == FRONT  && count == LAST_F) ? SYNC  :
               (phase == SYNC   && count == LAST_S) ? BACK  :
               (phase == BACK   && last)            ? ACTIVE : phase;
  // wrap flags the enabled step out of the final count of the axis
  always_comb begin
    last = count == LAST_B;
    wrap = en && last;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source; define VGA_SYNC_ALIGN_EN to delay hsync/vsync by PIPE_DEPTH cycles
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIDEO = DEF_H_VIDEO,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_VIDEO = DEF_V_VIDEO,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int PIPE_DEPTH = 2
) (
  input  logic               clk_0,
  input  logic               rst,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count
);
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic SYNC_ON = ~SYNC_ACTIVE_LOW;
  run_t state, state_nx;
  logic running, at_origin, h_wrap, unused_v_wrap, hs_r, vs_r;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  phase_t h_ph, v_ph;
  vga_axis_counter #(
    .VIDEO_LEN(H_VIDEO), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h (
    .clk_0(clk_0), .rst(rst), .en(1'b1), .count(h_cnt), .phase(h_ph), .wrap(h_wrap)
  );
  vga_axis_counter #(
    .VIDEO_LEN(V_VIDEO), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v (
    .clk_0(clk_0), .rst(rst), .en(h_wrap), .count(v_cnt), .phase(v_ph), .wrap(unused_v_wrap)
  );
  // run-control state register; its first post-reset edge also retimes the release
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // leave IDLE on the first edge after reset and stay in RUN
  always_comb state_nx = RUN;
  // the origin only counts as a new frame once the raster has already been running
  always_comb begin
    running = state == RUN;
    at_origin = h_cnt == '0 && v_cnt == '0;
  end
  // register every output from the same counter snapshot so they describe one position
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) begin
      pixel_x <= '0;
      pixel_y <= '0;
      video_on <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      hs_r <= SYNC_IDLE;
      vs_r <= SYNC_IDLE;
    end else begin
      pixel_x <= h_cnt;
      pixel_y <= v_cnt;
      video_on <= h_ph == ACTIVE && v_ph == ACTIVE;
      line_start <= h_cnt == '0;
      frame_start <= at_origin;
      frame_count <= frame_count + {7'd0, running && at_origin};
      hs_r <= h_ph == SYNC ? SYNC_ON : SYNC_IDLE;
      vs_r <= v_ph == SYNC ? SYNC_ON : SYNC_IDLE;
    end
`ifdef VGA_SYNC_ALIGN_EN
  logic [PIPE_DEPTH-1:0] hs_pipe, vs_pipe;
  // delay the syncs to line up with the renderer's colour pipeline
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) begin
      hs_pipe <= {PIPE_DEPTH{SYNC_IDLE}};
      vs_pipe <= {PIPE_DEPTH{SYNC_IDLE}};
    end else begin
      hs_pipe <= (hs_pipe << 1) | PIPE_DEPTH'(hs_r);
      vs_pipe <= (vs_pipe << 1) | PIPE_DEPTH'(vs_r);
    end
  assign hsync = hs_pipe[PIPE_DEPTH-1];
  assign vsync = vs_pipe[PIPE_DEPTH-1];
`else
  logic unused_pipe_depth;
  assign unused_pipe_depth = ^PIPE_DEPTH;
  assign hsync = hs_r;
  assign vsync = vs_r;
`endif
endmodule
